// File: rtl/line_window_buffer.sv
// line_window_buffer: raster pixel stream -> one WINxWIN window per interior pixel; WIN-1 line memories. LWB_SOF_SYNC_EN adds s_sof/sof_err resync.
// Latency: the window is valid the cycle after its completing pixel is accepted.
// Backpressure: s_ready = !m_valid || m_ready; all state holds while a window waits.
module line_window_buffer #(
    parameter int PIXEL_W    = 8,
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int WIN        = 3
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [PIXEL_W-1:0]           s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [WIN*WIN*PIXEL_W-1:0]   m_window,
    output logic                         m_last
`ifdef LWB_SOF_SYNC_EN
    ,
    input  logic                         s_sof,
    output logic                         sof_err
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int NL = WIN - 1;

    localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_EMIT = CW'(WIN - 1);
    localparam logic [RW-1:0] ROW_EMIT = RW'(WIN - 1);

    // [r][c] packs element (r,c) at bit offset (r*WIN+c)*PIXEL_W.
    typedef logic [WIN-1:0][WIN-1:0][PIXEL_W-1:0] win_t;

    logic [CW-1:0]      col_q;
    logic [RW-1:0]      row_q;
    logic [CW-1:0]      eff_col;
    logic [RW-1:0]      eff_row;
    logic               accept;
    logic               emit;
    logic               frame_end;
    logic [PIXEL_W-1:0] taps [NL];
    win_t               win_sr;
    win_t               win_nxt;
    win_t               win_out;

    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;

`ifdef LWB_SOF_SYNC_EN
    // A start-of-frame beat is placed at (0,0) regardless of where the counters were.
    assign eff_col = s_sof ? '0 : col_q;
    assign eff_row = s_sof ? '0 : row_q;
`else
    assign eff_col = col_q;
    assign eff_row = row_q;
`endif

    assign emit      = (eff_row >= ROW_EMIT) && (eff_col >= COL_EMIT);
    assign frame_end = (eff_row == ROW_MAX) && (eff_col == COL_MAX);

    // Each line memory reads its old value as a tap, then takes the tap of the row below.
    for (genvar k = 0; k < NL; k++) begin : g_line
        logic [PIXEL_W-1:0] mem [IMG_WIDTH];

        assign taps[k] = mem[eff_col];

        if (k == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (accept) begin
                    mem[eff_col] <= s_data;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk) begin
                if (accept) begin
                    mem[eff_col] <= taps[k-1];
                end
            end
        end
    end

    // Shift one column left; the new column enters on the right, oldest row on top.
    always_comb begin
        win_nxt = win_sr;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN - 1; c++) begin
                win_nxt[r][c] = win_sr[r][c+1];
            end
        end
        for (int r = 0; r < NL; r++) begin
            win_nxt[r][WIN-1] = taps[NL-1-r];
        end
        win_nxt[WIN-1][WIN-1] = s_data;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            col_q   <= '0;
            row_q   <= '0;
            win_sr  <= '0;
            win_out <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else begin
            if (accept) begin
                win_sr <= win_nxt;
                if (eff_col == COL_MAX) begin
                    col_q <= '0;
                    row_q <= (eff_row == ROW_MAX) ? '0 : eff_row + 1'b1;
                end else begin
                    col_q <= eff_col + 1'b1;
                    row_q <= eff_row;
                end
            end
            if (accept && emit) begin
                m_valid <= 1'b1;
                win_out <= win_nxt;
                m_last  <= frame_end;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    assign m_window = win_out;

`ifdef LWB_SOF_SYNC_EN
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sof_err <= 1'b0;
        end else begin
            sof_err <= accept && s_sof && ((col_q != '0) || (row_q != '0));
        end
    end
`endif

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer at 8x6 image, 3x3 window, pixel = row*16+col.
module tb_line_window_buffer;

    localparam int PW    = 8;
    localparam int W     = 8;
    localparam int H     = 6;
    localparam int K     = 3;
    localparam int NWIN  = (H - K + 1) * (W - K + 1);
    localparam int WW    = K * K * PW;
    localparam int LIMIT = 2000;

    logic          clk = 1'b0;
    logic          rstN;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [PW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [WW-1:0] m_window;
    logic          m_last;
`ifdef LWB_SOF_SYNC_EN
    logic          s_sof = 1'b0;
    logic          sof_err;
`endif

    int total = 0;
    int bad   = 0;
    int p_row = 0;
    int p_col = 0;
    int sof_cnt;
    int acc22_cyc;
    int first_vld_cyc;
    logic [WW-1:0] got_win  [$];
    logic          got_last [$];

    always #5 clk = ~clk;

    line_window_buffer #(
        .PIXEL_W   (PW),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .WIN       (K)
    ) dut (
        .clk     (clk),
        .rstN    (rstN),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_window(m_window),
        .m_last  (m_last)
`ifdef LWB_SOF_SYNC_EN
        ,
        .s_sof   (s_sof),
        .sof_err (sof_err)
`endif
    );

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Window k (emit order) has its top-left pixel at row k/6, col k%6.
    function automatic logic [WW-1:0] exp_win(input int k);
        logic [WW-1:0] w;
        int r0;
        int c0;
        w  = '0;
        r0 = k / (W - K + 1);
        c0 = k % (W - K + 1);
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                w[(r*K+c)*PW +: PW] = PW'((r0 + r) * 16 + c0 + c);
        return w;
    endfunction

    task automatic check_frames(input string tag, input int n);
        check({tag, " count"}, WW'(got_win.size()), WW'(n));
        for (int i = 0; i < got_win.size() && i < n; i++) begin
            check($sformatf("%s win%0d", tag, i), got_win[i], exp_win(i % NWIN));
            check($sformatf("%s last%0d", tag, i), WW'(got_last[i]), WW'(i % NWIN == NWIN - 1));
        end
        got_win.delete();
        got_last.delete();
    endtask

    // mode 0: continuous, 1: stall after first window, 2: random valid/ready.
    task automatic stream(input int n_pix, input int mode, input int sof_at, input bit drain);
        int acc = 0;
        int cyc = 0;
        int hold = 0;
        bit bp_started = 1'b0;
        bit prev_stall = 1'b0;
        logic [WW-1:0] prev_win = '0;
        acc22_cyc     = -1;
        first_vld_cyc = -1;
        sof_cnt       = 0;
        while ((acc < n_pix || (drain && m_valid)) && cyc < LIMIT) begin
            if (acc == sof_at) begin
                p_row = 0;
                p_col = 0;
            end
`ifdef LWB_SOF_SYNC_EN
            s_sof = (acc == sof_at);
`endif
            s_valid = (acc < n_pix) && (mode != 2 || $urandom_range(0, 3) != 0);
            s_data  = PW'(p_row * 16 + p_col);
            case (mode)
                1:       m_ready = bp_started && hold == 0;
                2:       m_ready = $urandom_range(0, 2) != 0;
                default: m_ready = 1'b1;
            endcase
            #1;
            if (prev_stall) begin
                check("stall keeps valid", WW'(m_valid), WW'(1));
                check("stall keeps window", m_window, prev_win);
            end
            if (m_valid && !m_ready) check("stall s_ready", WW'(s_ready), WW'(0));
            prev_stall = m_valid && !m_ready;
            prev_win   = m_window;
            if (m_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (mode == 1) begin
                if (bp_started && hold > 0) hold--;
                if (m_valid && !bp_started) begin
                    bp_started = 1'b1;
                    hold       = 4;
                end
            end
            if (m_valid && m_ready) begin
                got_win.push_back(m_window);
                got_last.push_back(m_last);
            end
`ifdef LWB_SOF_SYNC_EN
            if (sof_err) sof_cnt++;
`endif
            if (s_valid && s_ready) begin
                if (p_row == 2 && p_col == 2 && acc22_cyc < 0) acc22_cyc = cyc;
                acc++;
                if (p_col == W - 1) begin
                    p_col = 0;
                    p_row = (p_row == H - 1) ? 0 : p_row + 1;
                end else begin
                    p_col++;
                end
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
`ifdef LWB_SOF_SYNC_EN
        s_sof = 1'b0;
`endif
        check("stream within budget", WW'(cyc < LIMIT), WW'(1));
        if (acc22_cyc >= 0)
            check("first window latency", WW'(first_vld_cyc - acc22_cyc), WW'(1));
    endtask

    initial begin
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        check("reset m_valid", WW'(m_valid), WW'(0));
        check("reset m_last", WW'(m_last), WW'(0));
        check("reset m_window", m_window, '0);
        check("reset s_ready", WW'(s_ready), WW'(1));
`ifdef LWB_SOF_SYNC_EN
        check("reset sof_err", WW'(sof_err), WW'(0));
`endif
        rstN = 1'b1;
        @(negedge clk);

        stream(48, 0, -1, 1'b1);
        check_frames("basic", NWIN);

        stream(48, 1, -1, 1'b1);
        check_frames("backpressure", NWIN);

        stream(48, 2, -1, 1'b1);
        check_frames("random gaps", NWIN);

        stream(96, 0, -1, 1'b1);
        check_frames("two frames", 2 * NWIN);

        stream(20, 0, -1, 1'b0);
        check_frames("pre reset", 1);
        check("pending before reset", WW'(m_valid), WW'(1));
        #2 rstN = 1'b0;
        #1;
        check("async reset m_valid", WW'(m_valid), WW'(0));
        check("async reset m_window", m_window, '0);
        check("async reset m_last", WW'(m_last), WW'(0));
        repeat (2) @(negedge clk);
        check("held reset m_valid", WW'(m_valid), WW'(0));
        rstN  = 1'b1;
        p_row = 0;
        p_col = 0;
        stream(48, 0, -1, 1'b1);
        check_frames("after reset", NWIN);

`ifdef LWB_SOF_SYNC_EN
        stream(61, 0, 13, 1'b1);
        check_frames("resync", NWIN);
        check("resync sof_err pulses", WW'(sof_cnt), WW'(1));
        stream(48, 0, 0, 1'b1);
        check_frames("aligned sof", NWIN);
        check("aligned sof_err pulses", WW'(sof_cnt), WW'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_window_buffer.md
# line_window_buffer

Parametrised sliding-window generator for the edge-detection pixel pipeline. It takes a raster-order pixel stream and keeps WIN-1 previous image rows in internal line memories. For each accepted pixel that completes a fully interior WIN×WIN neighbourhood, it emits the whole window in one beat. It sits between the pixel source and the Gaussian/Sobel kernels, and it adds valid/ready flow control and frame tracking.

## Interface
- PIXEL_W, 8: bits per pixel.
- IMG_WIDTH, 512: pixels per row; must be ≥ WIN.
- IMG_HEIGHT, 512: rows per frame; must be ≥ WIN.
- WIN, 3: window edge length; must be odd, range 3..7.
- clk  in  1  clock.
- rstN  in  1  asynchronous, active-low reset.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  block can accept a pixel.
- s_data  in  PIXEL_W  input pixel in raster order.
- m_valid  out  1  output window valid.
- m_ready  in  1  downstream accepts the window.
- m_window  out  WIN*WIN*PIXEL_W  window. Element (r,c) occupies bits [(r*WIN+c)*PIXEL_W +: PIXEL_W]. r=0 is the top (oldest) row; c=0 is the leftmost column.
- m_last  out  1  marks the final window of a frame.
- s_sof  in  1  start-of-frame marker. Present only with LWB_SOF_SYNC_EN.
- sof_err  out  1  one-cycle resync error pulse. Present only with LWB_SOF_SYNC_EN.

## Operation
- A pixel is accepted when s_valid && s_ready.
- s_ready = !m_valid || m_ready. This is combinational; there is a single output register stage.
- col and row counters hold the position of the next pixel:
  - col has width $clog2(IMG_WIDTH); row has width $clog2(IMG_HEIGHT).
  - On accept, col increments. At IMG_WIDTH-1, col wraps to 0 and row increments.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0 and a new frame begins.
- Line memories L0..L(WIN-2) each hold IMG_WIDTH pixels. On accept at column c:
  - Read-before-write: taps t_k = L_k[c] (old contents).
  - Then L0[c] <= s_data and L_k[c] <= t_(k-1) for k ≥ 1.
- The column vector, top to bottom, is t_(WIN-2), ..., t_0, s_data.
- The window shift register shifts one column left on each accept; the new column enters at c=WIN-1.
- An accepted pixel at (row, col) is an emit position when row ≥ WIN-1 and col ≥ WIN-1.
  - On an emit accept: m_window is loaded with the shifted window and m_valid <= 1.
  - m_last <= 1 when the position is (IMG_HEIGHT-1, IMG_WIDTH-1); otherwise m_last <= 0.
- Non-emit accepts still update the memories and the shift register. m_valid <= 0 if the held window was consumed.
- If m_valid && m_ready and there is no emit accept, m_valid <= 0.
- Output count per frame: (IMG_HEIGHT-WIN+1)*(IMG_WIDTH-WIN+1) windows. No padding is applied.
- Line memory contents are never cleared. The first WIN-1 rows of each frame refill them before any emit.

## Timing
- Reset values: m_valid=0, m_last=0, m_window=0, sof_err=0, col=0, row=0.
- The shift register resets to 0. Line memories are not reset.
- Reset is asynchronous and may be asserted mid-frame. The next accepted pixel after release is treated as (0,0).
- Latency: a window appears on m_valid in the cycle after the emit-position pixel is accepted.
- Throughput: one pixel per cycle while m_ready=1.
- Back-pressure: while m_valid && !m_ready, s_ready=0, and m_window, m_last and all state hold stable.
- Simultaneous consume and accept: when m_valid && m_ready && s_valid, the new window loads in the same edge with no bubble.
- Row wrap: windows at col < WIN-1 contain previous-row columns and are never emitted.

## Configuration
- LWB_SOF_SYNC_EN defined: adds the s_sof and sof_err ports.
  - An accepted beat with s_sof=1 is forced to position (0,0), and counters continue from (0,1).
  - If the counters were not at (0,0) at that beat, sof_err pulses high for one cycle on the next clock.
  - A pending output window is unaffected.
- LWB_SOF_SYNC_EN undefined: no s_sof or sof_err ports; counters free-run and wrap purely by count.

## Test plan
All scenarios use IMG_WIDTH=8, IMG_HEIGHT=6, WIN=3, PIXEL_W=8, pixel = row*16+col, and m_ready=1 unless stated.
- Basic frame:
  - Stream 48 pixels -> exactly 24 windows.
  - First window appears one cycle after pixel (2,2): rows {00,01,02}, {10,11,12}, {20,21,22}.
  - Last window is {35,36,37}, {45,46,47}, {55,56,57} with m_last=1; m_last=0 on all other windows.
- Back-pressure: hold m_ready=0 for 5 cycles after the first window -> s_ready=0, m_window stable, no pixels lost; the window sequence is identical to basic frame.
- Random gaps: random s_valid and random m_ready -> the same 24 windows in the same order as basic frame.
- Back-to-back frames: stream two frames with no gap -> the second frame yields the same 24 windows with no stale rows (frame-2 first window equals frame-1 first window).
- Reset mid-frame: assert rstN=0 after 20 pixels, then stream a full frame -> m_valid=0 during reset, then exactly 24 correct windows.
- Resync (macro on): assert s_sof at pixel 13, then stream 48 pixels -> sof_err pulses once; windows match basic frame; s_sof at true (0,0) -> no sof_err.
